// File: rtl/sram_controller.sv
// sram_controller: synchronous host-side initiator for an asynchronous
// single-port SRAM. It turns one-cycle host requests into SETUP / ACCESS /
// HOLD sequenced SRAM cycles, then returns an Ack pulse and read data.
// Every SRAM-side output, Ack and RdData is driven straight from a flop.
module sram_controller #(
  parameter int AddressSize = 18,
  parameter int WordSize    = 8,
  parameter int WaitCycles  = 2   // strobe width in ACCESS, 1..15
) (
  input  logic                   Clock,
  input  logic                   bReset,
  input  logic                   Req,
  input  logic                   ReqWrite,
  input  logic [AddressSize-1:0] ReqAddress,
  input  logic [WordSize-1:0]    ReqData,
  output logic                   Ready,
  output logic                   Ack,
  output logic [WordSize-1:0]    RdData,
  output logic [AddressSize-1:0] SramAddress,
  output logic [WordSize-1:0]    SramWrData,
  input  logic [WordSize-1:0]    SramRdData,
  output logic                   SrambCE,
  output logic                   SrambWE
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    HOLD   = 2'd3
  } state_t;

  // The counter is loaded so that ACCESS lasts exactly WaitCycles cycles.
  localparam logic [3:0] WaitLoad = 4'(WaitCycles - 1);

  state_t     state;
  state_t     next_state;
  logic [3:0] wait_cnt;
  logic       is_write;

  // Idle is the only state in which a request can be taken.
  assign Ready = (state == IDLE);

  // State register.
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of the order the blocks are evaluated.
  always_ff @(posedge Clock or negedge bReset) begin
    if (!bReset) state <= IDLE;
    else         state <= next_state;
  end

  // Next-state decode: IDLE -> SETUP -> ACCESS (WaitCycles) -> HOLD -> IDLE.
  // NOTE: next_state gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (Req) next_state = SETUP;
      SETUP:   next_state = ACCESS;
      ACCESS:  if (wait_cnt == 4'd0) next_state = HOLD;
      HOLD:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Capture the request on acceptance; address/data then stay frozen
  // through SETUP, ACCESS and HOLD regardless of host-side activity.
  always_ff @(posedge Clock or negedge bReset) begin
    if (!bReset) begin
      is_write    <= 1'b0;
      SramAddress <= '0;
      SramWrData  <= '0;
    end else if (Ready && Req) begin
      is_write    <= ReqWrite;
      SramAddress <= ReqAddress;
      SramWrData  <= ReqData;
    end
  end

  // Strobe-width counter: loaded in SETUP, counted down through ACCESS.
  always_ff @(posedge Clock or negedge bReset) begin
    if (!bReset) begin
      wait_cnt <= 4'd0;
    end else if (state == SETUP) begin
      wait_cnt <= WaitLoad;
    end else if (state == ACCESS && wait_cnt != 4'd0) begin
      wait_cnt <= wait_cnt - 4'd1;
    end
  end

  // Registered strobes and Ack, decoded from the state being entered so they
  // line up with it. bWE falls on the same edge as bCE, never earlier, and
  // never on the edge that loads a new address.
  always_ff @(posedge Clock or negedge bReset) begin
    if (!bReset) begin
      SrambCE <= 1'b1;
      SrambWE <= 1'b1;
      Ack     <= 1'b0;
    end else begin
      SrambCE <= !(next_state == ACCESS);
      SrambWE <= !(next_state == ACCESS && is_write);
      Ack     <= (next_state == HOLD);
    end
  end

  // Read capture on the edge that leaves ACCESS; writes leave RdData alone.
  always_ff @(posedge Clock or negedge bReset) begin
    if (!bReset) begin
      RdData <= '0;
    end else if (state == ACCESS && wait_cnt == 4'd0 && !is_write) begin
      RdData <= SramRdData;
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// tb_sram_controller: directed bench for sram_controller. A behavioural
// SRAM model sits on the main instance (WaitCycles=2); two further instances
// with WaitCycles=1 and 15 are used to measure strobe width and latency.
module tb_sram_controller;

  logic        Clock = 1'b0;
  logic        bReset;
  logic        Req;
  logic        ReqWrite;
  logic [17:0] ReqAddress;
  logic [7:0]  ReqData;
  logic        Ready;
  logic        Ack;
  logic [7:0]  RdData;
  logic [17:0] SramAddress;
  logic [7:0]  SramWrData;
  logic [7:0]  SramRdData;
  logic        SrambCE;
  logic        SrambWE;

  // Auxiliary instances share the request fields but have their own Req.
  logic        aux_req;
  logic        ready_1, ack_1, ce_1, we_1;
  logic        ready_15, ack_15, ce_15, we_15;
  logic [7:0]  rd_1, rd_15, wd_1, wd_15;
  logic [17:0] addr_1, addr_15;

  int vectors     = 0;
  int miscompares = 0;
  logic [7:0] last_rd;

  // SRAM model: 256K x 8, written on a clock edge while bCE and bWE are low.
  logic [7:0] mem [0:(1<<18)-1];

  always #5 Clock = ~Clock;

  always @(posedge Clock) begin
    if (!SrambCE && !SrambWE) mem[SramAddress] <= SramWrData;
  end

  // Output bus carries the addressed word during reads; a marker otherwise.
  assign SramRdData = (!SrambCE && SrambWE) ? mem[SramAddress] : 8'hEE;

  sram_controller u_dut (
    .Clock(Clock), .bReset(bReset), .Req(Req), .ReqWrite(ReqWrite),
    .ReqAddress(ReqAddress), .ReqData(ReqData), .Ready(Ready), .Ack(Ack),
    .RdData(RdData), .SramAddress(SramAddress), .SramWrData(SramWrData),
    .SramRdData(SramRdData), .SrambCE(SrambCE), .SrambWE(SrambWE)
  );

  sram_controller #(.WaitCycles(1)) u_dut_w1 (
    .Clock(Clock), .bReset(bReset), .Req(aux_req), .ReqWrite(ReqWrite),
    .ReqAddress(ReqAddress), .ReqData(ReqData), .Ready(ready_1), .Ack(ack_1),
    .RdData(rd_1), .SramAddress(addr_1), .SramWrData(wd_1),
    .SramRdData(8'h00), .SrambCE(ce_1), .SrambWE(we_1)
  );

  sram_controller #(.WaitCycles(15)) u_dut_w15 (
    .Clock(Clock), .bReset(bReset), .Req(aux_req), .ReqWrite(ReqWrite),
    .ReqAddress(ReqAddress), .ReqData(ReqData), .Ready(ready_15), .Ack(ack_15),
    .RdData(rd_15), .SramAddress(addr_15), .SramWrData(wd_15),
    .SramRdData(8'h00), .SrambCE(ce_15), .SrambWE(we_15)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, got, exp);
    end
  endtask

  // Reset-state outputs of the main instance.
  task automatic check_idle_reset(input string tag);
    check({tag, "_ce"},    SrambCE,     1);
    check({tag, "_we"},    SrambWE,     1);
    check({tag, "_ack"},   Ack,         0);
    check({tag, "_ready"}, Ready,       1);
    check({tag, "_rd"},    RdData,      0);
    check({tag, "_addr"},  SramAddress, 0);
  endtask

  // One access on the main instance (WaitCycles=2), called at a negedge with
  // the controller idle; returns at the negedge of cycle 5 (Ready again).
  // hold keeps Req high throughout; noise scrambles host inputs while busy.
  task automatic run_access(input logic wr, input logic [17:0] addr,
                            input logic [7:0] data, input logic [7:0] exp_rd,
                            input bit hold, input bit noise);
    logic exp_ce, exp_we;
    Req = 1'b1; ReqWrite = wr; ReqAddress = addr; ReqData = data;
    check("ready_at_req", Ready, 1);
    for (int k = 1; k <= 5; k++) begin
      @(negedge Clock);
      if (!hold) Req = 1'b0;
      exp_ce = !(k == 2 || k == 3);
      exp_we = !((k == 2 || k == 3) && wr);
      if (k == 4 && !wr) last_rd = exp_rd;
      check("ce",    SrambCE, exp_ce);
      check("we",    SrambWE, exp_we);
      check("ack",   Ack,     k == 4);
      check("ready", Ready,   k == 5);
      check("rddata", RdData, last_rd);
      if (k <= 4) begin
        check("addr", SramAddress, addr);
        if (wr) check("wrdata", SramWrData, data);
      end
      if (noise && k <= 4) begin
        Req        = k[0];
        ReqWrite   = ~wr;
        ReqAddress = addr ^ 18'h2A5A5 ^ 18'(k);
        ReqData    = ~data;
      end
    end
  endtask

  initial begin
    int ce1_n, we1_n, ce15_n, we15_n, ack1_at, ack15_at;
    bReset = 1'b0; Req = 1'b0; aux_req = 1'b0;
    ReqWrite = 1'b0; ReqAddress = '0; ReqData = '0;
    last_rd = 8'h00;

    // 1: reset held for 3 cycles, then released.
    repeat (3) begin
      @(negedge Clock);
      check_idle_reset("rst");
    end
    bReset = 1'b1;
    @(negedge Clock);
    check_idle_reset("post_rst");

    // 2: write 0x00005 = 0xA5.
    run_access(1'b1, 18'h00005, 8'hA5, 8'h00, 1'b0, 1'b0);
    check("mem_00005", mem[18'h00005], 8'hA5);

    // 3: read 0x00005, then confirm RdData stays put while idle.
    run_access(1'b0, 18'h00005, 8'h00, 8'hA5, 1'b0, 1'b0);
    @(negedge Clock);
    check("rd_stable", RdData, 8'hA5);

    // 4: back-to-back with Req held high; top of the address range.
    run_access(1'b1, 18'h3FFFF, 8'hFF, 8'h00, 1'b1, 1'b0);
    check("mem_3ffff", mem[18'h3FFFF], 8'hFF);
    run_access(1'b0, 18'h3FFFF, 8'h00, 8'hFF, 1'b0, 1'b0);

    // 5: reset during the first ACCESS cycle of a write aborts it.
    @(negedge Clock);
    Req = 1'b1; ReqWrite = 1'b1; ReqAddress = 18'h00010; ReqData = 8'h77;
    @(negedge Clock);
    Req = 1'b0;
    @(negedge Clock);
    check("abort_in_access", SrambCE, 0);
    bReset = 1'b0;
    #1;
    last_rd = 8'h00;
    check_idle_reset("abort");
    repeat (2) begin
      @(negedge Clock);
      check("abort_ack", Ack, 0);
    end
    bReset = 1'b1;
    repeat (3) begin
      @(negedge Clock);
      check("after_abort_ack",   Ack,   0);
      check("after_abort_ready", Ready, 1);
    end
    run_access(1'b1, 18'h00000, 8'h3C, 8'h00, 1'b0, 1'b0);
    run_access(1'b0, 18'h00000, 8'h00, 8'h3C, 1'b0, 1'b0);

    // 6a: host activity while busy is ignored and nothing is queued.
    run_access(1'b0, 18'h00005, 8'h00, 8'hA5, 1'b0, 1'b1);
    Req = 1'b0;
    repeat (2) begin
      @(negedge Clock);
      check("noqueue_ready", Ready,   1);
      check("noqueue_ce",    SrambCE, 1);
      check("noqueue_addr",  SramAddress, 18'h00005);
    end

    // 6b: write on WaitCycles=1 and 15 instances; measure strobe widths.
    ReqWrite = 1'b1; ReqAddress = 18'h00005; ReqData = 8'hA5;
    aux_req = 1'b1;
    ce1_n = 0; we1_n = 0; ce15_n = 0; we15_n = 0; ack1_at = 0; ack15_at = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge Clock);
      aux_req = 1'b0;
      if (!ce_1)  ce1_n++;
      if (!we_1)  we1_n++;
      if (!ce_15) ce15_n++;
      if (!we_15) we15_n++;
      if (ack_1)  ack1_at  = k;
      if (ack_15) ack15_at = k;
    end
    check("w1_ce_width",   ce1_n,    1);
    check("w1_we_width",   we1_n,    1);
    check("w1_ack_cycle",  ack1_at,  3);
    check("w15_ce_width",  ce15_n,   15);
    check("w15_we_width",  we15_n,   15);
    check("w15_ack_cycle", ack15_at, 17);
    check("w1_ready",      ready_1,  1);
    check("w15_ready",     ready_15, 1);
    check("w15_addr",      addr_15,  18'h00005);
    check("w1_wrdata",     wd_1,     8'hA5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
